slave_bus_arbiter: RTL and testbench

SLAVE_BUS_ARBITER -- requirements
Module: slave_bus_arbiter

---
 rtl/slave_bus_arbiter_pkg.sv | 9 +
 rtl/rr_priority_picker.sv | 32 +++
 rtl/slave_bus_arbiter.sv | 111 +++++++++++
 tb/tb_slave_bus_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/slave_bus_arbiter_pkg.sv
// slave_bus_arbiter_pkg: FSM encoding, turnaround/gap timing and defaults shared by the arbiter files.
package slave_bus_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_XFER, ST_GAP} state_e;
  localparam int SETTLE_CYCLES = 1;
  localparam int GAP_CYCLES = 1;
  localparam int TMR_W = 2;
  localparam int SRC_W = 3;
  localparam int DEFAULT_MAX_FRAME = 255;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: round-robin pick of the first pending request after index last_i.
module rr_priority_picker
  import slave_bus_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [SRC_W-1:0] last_i,
  output logic [N-1:0]     onehot_o,
  output logic [SRC_W-1:0] idx_o,
  output logic             any_o
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  logic [SRC_W-1:0] c;
  logic [N-1:0]     rot;
  assign any_o = |req_i;
  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    onehot_o = '0;
    idx_o = '0;
    c = '0;
    rot = '0;
    for (int k = N; k >= 1; k--) begin
      c = SRC_W'((int'(last_i) + k) % N);
      rot = req_i >> c;
      if (rot[0]) begin
        onehot_o = ONE << c;
        idx_o = c;
      end
    end
  end
endmodule

// File: rtl/slave_bus_arbiter.sv
// slave_bus_arbiter: round-robin slave bus arbiter forwarding the granted requester's bytes downstream.
// Optional per-frame byte watchdog enabled with SL_ARB_WATCHDOG_EN.
module slave_bus_arbiter
  import slave_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_FRAME = DEFAULT_MAX_FRAME
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] sl_arb_request,
  output logic [NUM_REQ-1:0] sl_arb_grant,
  input  logic [7:0]         sl_data,
  output logic               sl_data_latch,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_data_valid,
  output logic               out_frame_valid,
  output logic [SRC_W-1:0]   out_src,
  output logic               err_timeout
);
  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SRC_W-1:0]   src_q, src_d, last_q, last_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [7:0]         data_q;
  logic               valid_q;
  logic [NUM_REQ-1:0] pick_oh;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic               req_win;
  logic               abort;
  rr_priority_picker #(.N(NUM_REQ)) u_pick (
    .req_i    (sl_arb_request),
    .last_i   (last_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );
  // Grant is one-hot while a frame is open, so masking picks the winner's request.
  assign req_win         = |(sl_arb_request & grant_q);
  assign sl_data_latch   = rst && (state_q == ST_XFER) && out_ready && req_win;
  assign sl_arb_grant    = grant_q;
  assign out_data        = data_q;
  assign out_data_valid  = valid_q;
  assign out_frame_valid = (state_q == ST_SETTLE) || (state_q == ST_XFER);
  assign out_src         = src_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    src_d = src_q;
    last_d = last_q;
    tmr_d = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
    case (state_q)
      ST_IDLE: if (pick_any) begin
        state_d = ST_SETTLE;
        grant_d = pick_oh;
        src_d = pick_idx;
        last_d = pick_idx;
        tmr_d = TMR_W'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: state_d = (tmr_q == '0) ? ST_XFER : ST_SETTLE;
      ST_XFER: if (!req_win || abort) begin
        state_d = ST_GAP;
        grant_d = '0;
        tmr_d = TMR_W'(GAP_CYCLES - 1);
      end
      ST_GAP: state_d = (tmr_q == '0) ? ST_IDLE : ST_GAP;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      src_q <= '0;
      last_q <= SRC_W'(NUM_REQ - 1);
      tmr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      src_q <= src_d;
      last_q <= last_d;
      tmr_q <= tmr_d;
      data_q <= sl_data_latch ? sl_data : data_q;
      valid_q <= sl_data_latch;
    end
  end
`ifdef SL_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(MAX_FRAME + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  assign abort       = sl_data_latch && (cnt_q == CNT_W'(MAX_FRAME - 1));
  assign err_timeout = err_q;
  // Counter restarts while idle, so each granted frame starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_IDLE) ? '0 : cnt_q + CNT_W'(sl_data_latch);
      err_q <= abort;
    end
  end
`else
  assign abort       = 1'b0;
  assign err_timeout = 1'b0 && (MAX_FRAME > 0);
`endif
endmodule

// File: tb/tb_slave_bus_arbiter.sv
// tb_slave_bus_arbiter: directed vector table plus hand-written fairness, reset and watchdog sequences.
module tb_slave_bus_arbiter;
  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [7:0] data;
    logic [3:0] grant;
    logic       latch;
    logic       ov;
    logic [7:0] od;
    logic       fv;
    logic [2:0] src;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [7:0] data;
  logic       latch;
  logic       rdy;
  logic [7:0] od;
  logic       ov;
  logic       fv;
  logic [2:0] src;
  logic       err;
  int total = 0;
  int bad = 0;
  vec_t vt[22];
  always #5 clk = ~clk;
  slave_bus_arbiter #(.NUM_REQ(4), .MAX_FRAME(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .sl_arb_request  (req),
    .sl_arb_grant    (grant),
    .sl_data         (data),
    .sl_data_latch   (latch),
    .out_ready       (rdy),
    .out_data        (od),
    .out_data_valid  (ov),
    .out_frame_valid (fv),
    .out_src         (src),
    .err_timeout     (err)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    rdy = 1'b1;
    data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask
  function automatic int oh2i(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction
  initial begin
    int order[$];
    int lat, gap, errs, nxt;
    logic [3:0] g, pg;
    vt = '{
      '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0},
      '{4'b0100, 1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0},
      '{4'b0100, 1'b1, 8'h00, 4'b0100, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2},
      '{4'b0100, 1'b1, 8'h03, 4'b0100, 1'b1, 1'b0, 8'h00, 1'b1, 3'd2},
      '{4'b0100, 1'b1, 8'hA1, 4'b0100, 1'b1, 1'b1, 8'h03, 1'b1, 3'd2},
      '{4'b0100, 1'b1, 8'hB2, 4'b0100, 1'b1, 1'b1, 8'hA1, 1'b1, 3'd2},
      '{4'b0000, 1'b1, 8'h00, 4'b0100, 1'b0, 1'b1, 8'hB2, 1'b1, 3'd2},
      '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 8'hB2, 1'b0, 3'd2},
      '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 8'hB2, 1'b0, 3'd2},
      '{4'b0001, 1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 8'hB2, 1'b0, 3'd2},
      '{4'b0001, 1'b1, 8'h00, 4'b0001, 1'b0, 1'b0, 8'hB2, 1'b1, 3'd0},
      '{4'b0001, 1'b1, 8'h11, 4'b0001, 1'b1, 1'b0, 8'hB2, 1'b1, 3'd0},
      '{4'b0011, 1'b0, 8'h22, 4'b0001, 1'b0, 1'b1, 8'h11, 1'b1, 3'd0},
      '{4'b0011, 1'b0, 8'h22, 4'b0001, 1'b0, 1'b0, 8'h11, 1'b1, 3'd0},
      '{4'b0011, 1'b1, 8'h22, 4'b0001, 1'b1, 1'b0, 8'h11, 1'b1, 3'd0},
      '{4'b0010, 1'b1, 8'h33, 4'b0001, 1'b0, 1'b1, 8'h22, 1'b1, 3'd0},
      '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h22, 1'b0, 3'd0},
      '{4'b0010, 1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h22, 1'b0, 3'd0},
      '{4'b0000, 1'b1, 8'h44, 4'b0010, 1'b0, 1'b0, 8'h22, 1'b1, 3'd1},
      '{4'b0000, 1'b1, 8'h44, 4'b0010, 1'b0, 1'b0, 8'h22, 1'b1, 3'd1},
      '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h22, 1'b0, 3'd1},
      '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h22, 1'b0, 3'd1}
    };
    rst = 1'b0;
    req = 4'hF;
    rdy = 1'b1;
    data = 8'h5A;
    #12;
    check("rst_grant", grant, 0);
    check("rst_latch", latch, 0);
    check("rst_od", od, 0);
    check("rst_ov", ov, 0);
    check("rst_fv", fv, 0);
    check("rst_src", src, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      req = vt[i].req;
      rdy = vt[i].rdy;
      data = vt[i].data;
      #1;
      check($sformatf("v%0d_grant", i), grant, vt[i].grant);
      check($sformatf("v%0d_latch", i), latch, vt[i].latch);
      check($sformatf("v%0d_ov", i), ov, vt[i].ov);
      check($sformatf("v%0d_od", i), od, vt[i].od);
      check($sformatf("v%0d_fv", i), fv, vt[i].fv);
      check($sformatf("v%0d_src", i), src, vt[i].src);
    end
    do_reset();
    lat = 0;
    gap = 0;
    pg = '0;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      @(negedge clk);
      g = grant;
      check("fair_onehot", 32'($onehot0(g)), 1);
      if (g != 0 && pg == 0) begin
        if (order.size() > 0) check("fair_gap", gap, 2);
        order.push_back(oh2i(g));
        lat = 0;
      end
      gap = (g == 0) ? gap + 1 : 0;
      req = (g != 0 && lat >= 2) ? ~g : 4'hF;
      data = 8'(c);
      #1;
      if (latch) lat++;
      pg = g;
    end
    check("fair_count", order.size(), 5);
    for (int i = 0; i < order.size(); i++) check($sformatf("fair_order%0d", i), order[i], i % 4);
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    data = 8'h77;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rm_latch_pre", latch, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rm_grant", grant, 0);
    check("rm_latch", latch, 0);
    check("rm_fv", fv, 0);
    check("rm_ov", ov, 0);
    check("rm_src", src, 0);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0101;
    @(negedge clk);
    #1;
    check("rm_first_grant", grant, 4'b0001);
    check("rm_first_src", src, 0);
`ifdef SL_ARB_WATCHDOG_EN
    do_reset();
    req = 4'b1010;
    lat = 0;
    errs = 0;
    nxt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (grant == 4'b0010 && latch) lat++;
      if (err) errs++;
      if (grant == 4'b1000) begin
        nxt = 1;
        break;
      end
    end
    check("wd_latches", lat, 4);
    check("wd_err", errs, 1);
    check("wd_next", nxt, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
